// File: rtl/adder_accumulator.sv
// Adder accumulator: sums COUNT results from a 4-bit adder stage
// ({C_out,sum}, 0..31) into an ACC_W-bit frame total, then offers the total
// downstream with a valid/ready handshake. Overflow is sticky per frame.
module adder_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       sum,
    input  logic             C_out,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W:0]   acc_next;

    // Zero-extend the 5-bit adder result and form the wide sum whose top bit is the wrap carry
    always_comb begin
        sample_ext      = '0;
        sample_ext[4:0] = {C_out, sum};
        acc_next        = {1'b0, acc_out} + {1'b0, sample_ext};
    end

    // Frame FSM with all outputs registered alongside the state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            acc_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_out <= acc_next[ACC_W-1:0];
                        if (acc_next[ACC_W]) begin
                            overflow <= 1'b1;
                        end
                        count <= count + CNT_ONE;
                        if (count == LAST_IDX) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            acc_out  <= '0;
                            overflow <= 1'b0;
                            count    <= '0;
                            state    <= ACC;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    count     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed testbench for adder_accumulator: a default instance (ACC_W=8,
// COUNT=4) and a COUNT=9 instance share the same stimulus.
module tb_adder_accumulator;

    logic       Clock;
    logic       Reset;
    logic       start;
    logic       in_valid;
    logic [3:0] sum;
    logic       C_out;
    logic       out_ready;

    logic [7:0] acc_out;
    logic       out_valid;
    logic       overflow;
    logic       busy;

    logic [7:0] acc_out9;
    logic       out_valid9;
    logic       overflow9;
    logic       busy9;

    int vectors = 0;
    int errors  = 0;

    adder_accumulator dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .in_valid  (in_valid),
        .sum       (sum),
        .C_out     (C_out),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    adder_accumulator #(.ACC_W(8), .COUNT(9)) dut9 (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .in_valid  (in_valid),
        .sum       (sum),
        .C_out     (C_out),
        .out_ready (out_ready),
        .acc_out   (acc_out9),
        .out_valid (out_valid9),
        .overflow  (overflow9),
        .busy      (busy9)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and settle just after the rising edge
    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    // Present one adder result (valid or not) for a single cycle
    task automatic drive_sample(input logic [4:0] v, input logic valid);
        {C_out, sum} = v;
        in_valid = valid;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (acc_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_acc: got %0d expected 0", acc_out); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        pulse_start();
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %b expected 1", busy); end
        drive_sample(5'd5, 1'b1);
        drive_sample(5'd31, 1'b1);
        drive_sample(5'd0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid); end
        vectors++;
        if (acc_out !== 8'd36) begin errors++; $display("[TB] FAIL basic_partial: got %0d expected 36", acc_out); end
        drive_sample(5'd16, 1'b1);
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
        vectors++;
        if (acc_out !== 8'd52) begin errors++; $display("[TB] FAIL basic_acc: got %0d expected 52", acc_out); end
        vectors++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", overflow); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_handshake_valid: got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_handshake_busy: got %b expected 0", busy); end
    endtask

    task automatic test_gaps();
        logic [4:0] vals [7];
        logic       vlds [7];
        vals = '{5'd3, 5'd31, 5'd31, 5'd4, 5'd31, 5'd5, 5'd6};
        vlds = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            drive_sample(vals[i], vlds[i]);
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gaps_early_valid[%0d]: got %b expected 0", i, out_valid); end
        end
        vectors++;
        if (acc_out !== 8'd12) begin errors++; $display("[TB] FAIL gaps_partial: got %0d expected 12", acc_out); end
        drive_sample(vals[6], vlds[6]);
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL gaps_valid: got %b expected 1", out_valid); end
        vectors++;
        if (acc_out !== 8'd18) begin errors++; $display("[TB] FAIL gaps_acc: got %0d expected 18", acc_out); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            drive_sample(5'd31, 1'b1);
        end
        vectors++;
        if (acc_out9 !== 8'd248) begin errors++; $display("[TB] FAIL ovf_partial: got %0d expected 248", acc_out9); end
        vectors++;
        if (overflow9 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow9); end
        vectors++;
        if (out_valid9 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early_valid: got %b expected 0", out_valid9); end
        drive_sample(5'd31, 1'b1);
        vectors++;
        if (acc_out9 !== 8'd23) begin errors++; $display("[TB] FAIL ovf_acc: got %0d expected 23", acc_out9); end
        vectors++;
        if (overflow9 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow9); end
        vectors++;
        if (out_valid9 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: got %b expected 1", out_valid9); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        vectors++;
        if (overflow9 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_idle: got %b expected 1", overflow9); end
        pulse_start();
        vectors++;
        if (overflow9 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b expected 0", overflow9); end
        vectors++;
        if (acc_out9 !== 8'd0) begin errors++; $display("[TB] FAIL ovf_acc_cleared: got %0d expected 0", acc_out9); end
    endtask

    task automatic test_hold();
        do_reset();
        pulse_start();
        drive_sample(5'd1, 1'b1);
        drive_sample(5'd2, 1'b1);
        drive_sample(5'd3, 1'b1);
        drive_sample(5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            drive_sample(5'd7, 1'b1);
            start = 1'b0;
            vectors++;
            if (acc_out !== 8'd10) begin errors++; $display("[TB] FAIL hold_acc[%0d]: got %0d expected 10", i, acc_out); end
            vectors++;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            vectors++;
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy[%0d]: got %b expected 1", i, busy); end
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_busy: got %b expected 0", busy); end
        drive_sample(5'd9, 1'b1);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignores_valid: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        drive_sample(5'd7, 1'b1);
        drive_sample(5'd9, 1'b1);
        Reset     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        drive_sample(5'd5, 1'b1);
        Reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (acc_out !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_acc: got %0d expected 0", acc_out); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b expected 0", out_valid); end
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_sample(5'd1, 1'b1);
        end
        vectors++;
        if (acc_out !== 8'd4) begin errors++; $display("[TB] FAIL rstmid_fresh_acc: got %0d expected 4", acc_out); end
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_fresh_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        drive_sample(5'd10, 1'b1);
        start = 1'b1;
        drive_sample(5'd20, 1'b1);
        start = 1'b0;
        vectors++;
        if (acc_out !== 8'd30) begin errors++; $display("[TB] FAIL b2b_midstart: got %0d expected 30", acc_out); end
        drive_sample(5'd1, 1'b1);
        drive_sample(5'd2, 1'b1);
        vectors++;
        if (acc_out !== 8'd33) begin errors++; $display("[TB] FAIL b2b_acc: got %0d expected 33", acc_out); end
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        start     = 1'b1;
        cycle();
        out_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if (acc_out !== 8'd0) begin errors++; $display("[TB] FAIL b2b_new_acc: got %0d expected 0", acc_out); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_new_valid: got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_new_busy: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            drive_sample(5'd31, 1'b1);
        end
        vectors++;
        if (acc_out !== 8'd124) begin errors++; $display("[TB] FAIL b2b_second_acc: got %0d expected 124", acc_out); end
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_valid: got %b expected 1", out_valid); end
        vectors++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_ovf: got %b expected 0", overflow); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        Reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        sum       = 4'd0;
        C_out     = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
